idex_pipe: RTL and testbench

Parametrised ID/EX pipeline stage with a valid/ready handshake, a one-entry skid buffer, stall and flush, and operand forwarding ahead of the A/B operand muxes. It sits between decode and the ALU. It captures the decoded operands, PC, branch info and destination register, and presents them to execute. Unlike the earlier single-register stage, it can apply back-pressure without losing an instruction, can drop in-flight work on a flush, and generalises data and register-address width.

---
 rtl/idex_pipe_pkg.sv | 22 ++
 rtl/idex_pipe_if.sv | 47 ++++
 rtl/idex_pipe_skid_buf.sv | 73 +++++++
 rtl/idex_pipe.sv | 89 ++++++++
 tb/tb_idex_pipe.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/idex_pipe_pkg.sv
// idex_pkg: shared types and constants for the ID/EX pipeline stage.
//   a_sel_e   - operand A source select
//   b_sel_e   - operand B source select
//   fwd_sel_e - forwarding source for rs1/rs2
//   payload_bits() - width of the packed payload for a given word/reg width
package idex_pkg;

  typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2, A_ZERO2 = 2'd3} a_sel_e;
  typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2, B_UIMM = 2'd3} b_sel_e;
  typedef enum logic [1:0] {F_RF = 2'd0, F_EX = 2'd1, F_MEM = 2'd2, F_RF2 = 2'd3} fwd_sel_e;

  // Upper-immediate operand is imm shifted left by this amount, truncated to the word.
  localparam int IMM_UPPER_SHIFT = 12;
  // Constant operand used for link-address (pc + 4) style computations.
  localparam int B_FOUR_CONST    = 4;

  // branch_taken + rdn + five word-sized fields (pc, branch_addr, a, b, rs2d).
  function automatic int payload_bits(input int word_size, input int reg_addr_width);
    return 1 + reg_addr_width + 5 * word_size;
  endfunction

endpackage

// File: rtl/idex_pipe_if.sv
// idex_pipe_if: decode-side and execute-side signals of the ID/EX stage.
//   master - driven by the surrounding pipeline (decode payload, forwards, out_ready, flush)
//   slave  - used by idex_pipe (produces in_ready and the execute payload)
interface idex_pipe_if #(
  parameter int WordSize     = 32,
  parameter int RegAddrWidth = 5
);
  // decode side
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic                    branch_taken_in;
  logic [1:0]              a_sel;
  logic [1:0]              b_sel;
  logic [1:0]              fwd_a_sel;
  logic [1:0]              fwd_b_sel;
  logic [WordSize-1:0]     pc_in;
  logic [WordSize-1:0]     imm;
  logic [WordSize-1:0]     rs1d;
  logic [WordSize-1:0]     rs2d_in;
  logic [WordSize-1:0]     branch_addr_in;
  logic [WordSize-1:0]     ex_fwd;
  logic [WordSize-1:0]     mem_fwd;
  logic [RegAddrWidth-1:0] rdn_in;
  // execute side
  logic                    out_valid;
  logic                    out_ready;
  logic                    branch_taken;
  logic [RegAddrWidth-1:0] rdn;
  logic [WordSize-1:0]     pc;
  logic [WordSize-1:0]     branch_addr;
  logic [WordSize-1:0]     a;
  logic [WordSize-1:0]     b;
  logic [WordSize-1:0]     rs2d;

  modport master (
    output in_valid, flush, branch_taken_in, a_sel, b_sel, fwd_a_sel, fwd_b_sel,
           pc_in, imm, rs1d, rs2d_in, branch_addr_in, ex_fwd, mem_fwd, rdn_in, out_ready,
    input  in_ready, out_valid, branch_taken, rdn, pc, branch_addr, a, b, rs2d
  );

  modport slave (
    input  in_valid, flush, branch_taken_in, a_sel, b_sel, fwd_a_sel, fwd_b_sel,
           pc_in, imm, rs1d, rs2d_in, branch_addr_in, ex_fwd, mem_fwd, rdn_in, out_ready,
    output in_ready, out_valid, branch_taken, rdn, pc, branch_addr, a, b, rs2d
  );
endinterface

// File: rtl/idex_pipe_skid_buf.sv
// pipe_skid_buf: valid/ready pipeline register with a one-entry skid and flush.
//   clk, rst      - clock, synchronous active-high reset (clears data too)
//   flush_i       - drop both entries and any payload arriving this cycle
//   in_*_i/o      - upstream handshake and payload; in_ready_o is registered
//   out_*_i/o     - downstream handshake and payload (straight from the main register)
module pipe_skid_buf #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);
  logic [Width-1:0] main_q, main_d, skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             can_adv, in_fire;

  assign can_adv = !main_valid_q || out_ready_i;
  assign in_fire = in_valid_i && in_ready_q;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (can_adv && skid_valid_q) begin
      // in_ready is low whenever the skid holds data, so no in_fire here.
      main_d       = skid_q;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else if (can_adv && in_fire) begin
      main_d       = in_data_i;
      main_valid_d = 1'b1;
    end else if (can_adv) begin
      main_valid_d = 1'b0;
    end else if (in_fire) begin
      skid_d       = in_data_i;
      skid_valid_d = 1'b1;
    end
    // Registered ready: accept next cycle only if the skid will be empty.
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;
endmodule

// File: rtl/idex_pipe.sv
// idex_pipe: ID/EX pipeline stage. Forwards rs1/rs2, selects the A/B operands,
// packs the execute payload and hands it to a skid-buffered pipeline register.
//   clk, rst - clock, synchronous active-high reset
//   bus      - idex_pipe_if slave: decode payload + in_valid/in_ready, flush,
//              forwarded results, execute payload + out_valid/out_ready
module idex_pipe
  import idex_pkg::*;
#(
  parameter int WordSize     = 32,
  parameter int RegAddrWidth = 5
) (
  input logic        clk,
  input logic        rst,
  idex_pipe_if.slave bus
);
  typedef struct packed {
    logic                    branch_taken;
    logic [RegAddrWidth-1:0] rdn;
    logic [WordSize-1:0]     pc;
    logic [WordSize-1:0]     branch_addr;
    logic [WordSize-1:0]     a;
    logic [WordSize-1:0]     b;
    logic [WordSize-1:0]     rs2d;
  } idex_payload_t;

  localparam int PayloadBits = payload_bits(WordSize, RegAddrWidth);

  logic [WordSize-1:0] rs1f, rs2f, op_a, op_b;
  idex_payload_t       in_pl, out_pl;

  // Forwarding happens before the operand muxes so that pc/imm selects are
  // unaffected and the stored rs2d is the forwarded store data.
  always_comb begin
    case (fwd_sel_e'(bus.fwd_a_sel))
      F_EX:    rs1f = bus.ex_fwd;
      F_MEM:   rs1f = bus.mem_fwd;
      default: rs1f = bus.rs1d;
    endcase
    case (fwd_sel_e'(bus.fwd_b_sel))
      F_EX:    rs2f = bus.ex_fwd;
      F_MEM:   rs2f = bus.mem_fwd;
      default: rs2f = bus.rs2d_in;
    endcase
  end

  always_comb begin
    case (a_sel_e'(bus.a_sel))
      A_RS1:   op_a = rs1f;
      A_PC:    op_a = bus.pc_in;
      default: op_a = '0;
    endcase
    case (b_sel_e'(bus.b_sel))
      B_RS2:   op_b = rs2f;
      B_IMM:   op_b = bus.imm;
      B_FOUR:  op_b = WordSize'(B_FOUR_CONST);
      default: op_b = bus.imm << IMM_UPPER_SHIFT;  // upper bits fall off the word
    endcase
  end

  always_comb begin
    in_pl.branch_taken = bus.branch_taken_in;
    in_pl.rdn          = bus.rdn_in;
    in_pl.pc           = bus.pc_in;
    in_pl.branch_addr  = bus.branch_addr_in;
    in_pl.a            = op_a;
    in_pl.b            = op_b;
    in_pl.rs2d         = rs2f;
  end

  pipe_skid_buf #(.Width(PayloadBits)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (bus.flush),
    .in_valid_i (bus.in_valid),
    .in_ready_o (bus.in_ready),
    .in_data_i  (in_pl),
    .out_valid_o(bus.out_valid),
    .out_ready_i(bus.out_ready),
    .out_data_o (out_pl)
  );

  assign bus.branch_taken = out_pl.branch_taken;
  assign bus.rdn          = out_pl.rdn;
  assign bus.pc           = out_pl.pc;
  assign bus.branch_addr  = out_pl.branch_addr;
  assign bus.a            = out_pl.a;
  assign bus.b            = out_pl.b;
  assign bus.rs2d         = out_pl.rs2d;
endmodule

// File: tb/tb_idex_pipe.sv
module tb_idex_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  idex_pipe_if #(.WordSize(32), .RegAddrWidth(5)) bus ();
  idex_pipe #(.WordSize(32), .RegAddrWidth(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  idex_pipe_if #(.WordSize(64), .RegAddrWidth(5)) bus64 ();
  idex_pipe #(.WordSize(64), .RegAddrWidth(5)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit [1:0]  a_sel, b_sel, fa, fb;
    bit [31:0] pc, imm, rs1, rs2, ex, mem;
    bit [31:0] ea, eb, ers2;
  } vec_t;

  typedef struct {
    bit        bt;
    bit [4:0]  rd;
    bit [31:0] pc, ba, a, b, rs2;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit [1:0] a_sel, bit [1:0] b_sel, bit [1:0] fa, bit [1:0] fb,
                              bit [31:0] pc, bit [31:0] imm, bit [31:0] rs1, bit [31:0] rs2,
                              bit [31:0] ex, bit [31:0] mem,
                              bit [31:0] ea, bit [31:0] eb, bit [31:0] ers2);
    vec_t v;
    v.a_sel = a_sel; v.b_sel = b_sel; v.fa = fa; v.fb = fb;
    v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.ex = ex; v.mem = mem;
    v.ea = ea; v.eb = eb; v.ers2 = ers2;
    return v;
  endfunction

  task automatic drive(input vec_t v, input int tag);
    bus.a_sel = v.a_sel; bus.b_sel = v.b_sel; bus.fwd_a_sel = v.fa; bus.fwd_b_sel = v.fb;
    bus.pc_in = v.pc; bus.imm = v.imm; bus.rs1d = v.rs1; bus.rs2d_in = v.rs2;
    bus.ex_fwd = v.ex; bus.mem_fwd = v.mem;
    bus.branch_addr_in = v.pc + 32'h1000;
    bus.rdn_in = 5'(tag);
    bus.branch_taken_in = tag[0];
  endtask

  // Simple pc-as-A instruction for the multi-cycle sequences.
  task automatic drive_pc(input bit [31:0] pcv);
    drive(mk(2'd1, 2'd2, 2'd0, 2'd0, pcv, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, pcv, 32'd4, 32'h0), 1);
  endtask

  task automatic randomize_inputs();
    bus.a_sel = 2'($urandom); bus.b_sel = 2'($urandom);
    bus.fwd_a_sel = 2'($urandom); bus.fwd_b_sel = 2'($urandom);
    bus.pc_in = $urandom; bus.imm = $urandom; bus.rs1d = $urandom; bus.rs2d_in = $urandom;
    bus.ex_fwd = $urandom; bus.mem_fwd = $urandom; bus.branch_addr_in = $urandom;
    bus.rdn_in = 5'($urandom); bus.branch_taken_in = 1'($urandom);
  endtask

  // Reference: operand selection written directly from the select tables.
  function automatic exp_t model_payload();
    exp_t e;
    bit [31:0] src1 [4];
    bit [31:0] src2 [4];
    bit [31:0] opa [4];
    bit [31:0] opb [4];
    bit [63:0] wide;
    src1 = '{bus.rs1d, bus.ex_fwd, bus.mem_fwd, bus.rs1d};
    src2 = '{bus.rs2d_in, bus.ex_fwd, bus.mem_fwd, bus.rs2d_in};
    wide = 64'(bus.imm) * 64'd4096;
    opa  = '{src1[bus.fwd_a_sel], bus.pc_in, 32'd0, 32'd0};
    opb  = '{src2[bus.fwd_b_sel], bus.imm, 32'd4, wide[31:0]};
    e.bt  = bus.branch_taken_in;
    e.rd  = bus.rdn_in;
    e.pc  = bus.pc_in;
    e.ba  = bus.branch_addr_in;
    e.a   = opa[bus.a_sel];
    e.b   = opb[bus.b_sel];
    e.rs2 = src2[bus.fwd_b_sel];
    return e;
  endfunction

  // 64-bit instance: constant upper-immediate instruction streaming every cycle.
  initial begin
    bus64.in_valid = 1'b1; bus64.out_ready = 1'b1; bus64.flush = 1'b0;
    bus64.branch_taken_in = 1'b0; bus64.a_sel = 2'd2; bus64.b_sel = 2'd3;
    bus64.fwd_a_sel = 2'd0; bus64.fwd_b_sel = 2'd0;
    bus64.pc_in = '0; bus64.imm = 64'h0000_0000_000A_BCDE; bus64.rs1d = '0; bus64.rs2d_in = '0;
    bus64.branch_addr_in = '0; bus64.ex_fwd = '0; bus64.mem_fwd = '0; bus64.rdn_in = '0;
  end

  vec_t vt [10];

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.flush = 1'b0;
    randomize_inputs();
    bus.in_valid = 1'($urandom); bus.out_ready = 1'($urandom);

    // ---------------- reset ----------------
    step();
    randomize_inputs();
    step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_a", 64'(bus.a), 64'd0);
    chk("rst_b", 64'(bus.b), 64'd0);
    chk("rst_pc", 64'(bus.pc), 64'd0);
    chk("rst_misc", 64'({bus.branch_taken, bus.rdn, bus.branch_addr, bus.rs2d}), 64'd0);
    $display("txn reset done");
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;

    // ---------------- table: streaming, forwarding, immediates ----------------
    vt[0] = mk(2'd1, 2'd2, 2'd0, 2'd0, 32'h100, 32'h0, 32'h0, 32'h55, 32'h0, 32'h0, 32'h100, 32'd4, 32'h55);
    vt[1] = mk(2'd1, 2'd2, 2'd0, 2'd0, 32'h104, 32'h0, 32'h0, 32'h55, 32'h0, 32'h0, 32'h104, 32'd4, 32'h55);
    vt[2] = mk(2'd1, 2'd2, 2'd0, 2'd0, 32'h108, 32'h0, 32'h0, 32'h55, 32'h0, 32'h0, 32'h108, 32'd4, 32'h55);
    vt[3] = mk(2'd1, 2'd2, 2'd0, 2'd0, 32'h10C, 32'h0, 32'h0, 32'h55, 32'h0, 32'h0, 32'h10C, 32'd4, 32'h55);
    vt[4] = mk(2'd0, 2'd0, 2'd1, 2'd2, 32'h20, 32'h0, 32'd1, 32'd2, 32'd7, 32'd9, 32'd7, 32'd9, 32'd9);
    vt[5] = mk(2'd2, 2'd3, 2'd0, 2'd0, 32'h24, 32'h000ABCDE, 32'h11, 32'h33, 32'h0, 32'h0, 32'd0, 32'hABCDE000, 32'h33);
    vt[6] = mk(2'd3, 2'd3, 2'd0, 2'd0, 32'h28, 32'hFFFFFFFF, 32'h11, 32'h44, 32'h0, 32'h0, 32'd0, 32'hFFFFF000, 32'h44);
    vt[7] = mk(2'd0, 2'd1, 2'd3, 2'd0, 32'h2C, 32'h1234, 32'hAA, 32'h66, 32'hBB, 32'hCC, 32'hAA, 32'h1234, 32'h66);
    vt[8] = mk(2'd0, 2'd0, 2'd2, 2'd1, 32'h30, 32'h0, 32'hAA, 32'h66, 32'hBB, 32'hCC, 32'hCC, 32'hBB, 32'hBB);
    vt[9] = mk(2'd0, 2'd0, 2'd0, 2'd3, 32'h34, 32'h0, 32'hDD, 32'h77, 32'h1, 32'h2, 32'hDD, 32'h77, 32'h77);
    for (int i = 0; i < 10; i++) begin
      drive(vt[i], i);
      bus.in_valid = 1'b1;
      step();
      chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("vec%0d_a", i), 64'(bus.a), 64'(vt[i].ea));
      chk($sformatf("vec%0d_b", i), 64'(bus.b), 64'(vt[i].eb));
      chk($sformatf("vec%0d_rs2d", i), 64'(bus.rs2d), 64'(vt[i].ers2));
      chk($sformatf("vec%0d_pc", i), 64'(bus.pc), 64'(vt[i].pc));
      chk($sformatf("vec%0d_tag", i), 64'({bus.branch_taken, bus.rdn, bus.branch_addr}),
          64'({i[0], 5'(i), vt[i].pc + 32'h1000}));
      $display("txn vec%0d pc=%0h a=%0h b=%0h rs2d=%0h", i, bus.pc, bus.a, bus.b, bus.rs2d);
    end
    bus.in_valid = 1'b0;
    step();
    chk("stream_drain", 64'(bus.out_valid), 64'd0);

    chk("w64_valid", 64'(bus64.out_valid), 64'd1);
    chk("w64_uimm", bus64.b, 64'h0000_0000_ABCD_E000);
    $display("txn w64 b=%0h", bus64.b);

    // ---------------- stall / skid ----------------
    bus.out_ready = 1'b0;
    drive_pc(32'h200); bus.in_valid = 1'b1; step();
    chk("stall_i1_a", 64'(bus.a), 64'h200);
    chk("stall_i1_rdy", 64'(bus.in_ready), 64'd1);
    drive_pc(32'h204); step();
    chk("stall_skid_rdy", 64'(bus.in_ready), 64'd0);
    chk("stall_hold_a", 64'(bus.a), 64'h200);
    drive_pc(32'h208); step();
    chk("stall_held_rdy", 64'(bus.in_ready), 64'd0);
    chk("stall_held_a", 64'(bus.a), 64'h200);
    bus.out_ready = 1'b1; step();
    chk("release_i2_a", 64'(bus.a), 64'h204);
    chk("release_rdy", 64'(bus.in_ready), 64'd1);
    step();
    chk("release_i3_valid", 64'(bus.out_valid), 64'd1);
    chk("release_i3_a", 64'(bus.a), 64'h208);
    bus.in_valid = 1'b0; step();
    chk("release_drain", 64'(bus.out_valid), 64'd0);
    $display("txn stall/skid sequence done");

    // ---------------- flush while stalled with skid full ----------------
    bus.out_ready = 1'b0;
    drive_pc(32'h300); bus.in_valid = 1'b1; step();
    drive_pc(32'h304); step();
    drive_pc(32'h308); bus.flush = 1'b1; step();
    bus.flush = 1'b0;
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_rdy", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("flush_quiet%0d", i), 64'(bus.out_valid), 64'd0);
    end
    $display("txn flush sequence done");

    // ---------------- reset while stalled ----------------
    bus.out_ready = 1'b0;
    drive_pc(32'h400); bus.in_valid = 1'b1; step();
    drive_pc(32'h404); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_rdy", 64'(bus.in_ready), 64'd1);
    chk("rst_mid_data", 64'(bus.pc ^ bus.a), 64'd0);
    bus.in_valid = 1'b0;
    $display("txn reset-mid-stall done");

    // ---------------- randomized against the occupancy model ----------------
    q.delete();
    for (int c = 0; c < 400; c++) begin
      bit in_fire, out_fire;
      chk("rnd_out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      chk("rnd_in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      if (q.size() != 0 && bus.out_valid) begin
        chk("rnd_a", 64'(bus.a), 64'(q[0].a));
        chk("rnd_b", 64'(bus.b), 64'(q[0].b));
        chk("rnd_rs2d", 64'(bus.rs2d), 64'(q[0].rs2));
        chk("rnd_pc", 64'(bus.pc), 64'(q[0].pc));
        chk("rnd_tag", 64'({bus.branch_taken, bus.rdn, bus.branch_addr}),
            64'({q[0].bt, q[0].rd, q[0].ba}));
      end
      randomize_inputs();
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 29) == 0);
      in_fire  = bus.in_valid && bus.in_ready;
      out_fire = bus.out_valid && bus.out_ready;
      if (bus.flush) begin
        q.delete();
      end else begin
        if (out_fire && q.size() != 0) begin
          $display("txn rnd out pc=%0h a=%0h b=%0h", bus.pc, bus.a, bus.b);
          void'(q.pop_front());
        end
        if (in_fire) q.push_back(model_payload());
      end
      step();
    end
    bus.flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
